// File: rtl/chaos_map_pkg.sv
// Shared types and constants for the basic chaotic-map iteration controllers.
package chaos_map_pkg;

   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned CNT_W_DEF   = 16;
   localparam int unsigned MAP_LAT_MAX = 15;
   localparam int unsigned LAT_W       = $clog2(MAP_LAT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/chaos_map_iter_ctrl.sv
// Iteration sequencer for an external basic chaotic map: runs a warmup transient,
// then streams successive map states over a valid/ready interface.
module chaos_map_iter_ctrl
   import chaos_map_pkg::*;
#(
   parameter int unsigned DATA_W  = DATA_W_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned MAP_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] seed,
   input  logic [DATA_W-1:0] ratio,
   input  logic [CNT_W-1:0]  warmup,
   input  logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] map_x_o,
   output logic [DATA_W-1:0] map_ratio_o,
   input  logic [DATA_W-1:0] map_x_next_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data
);

   localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MAP_LAT - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] x_q, x_d;
   logic [DATA_W-1:0] ratio_q, ratio_d;
   logic [CNT_W-1:0]  warm_q, warm_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              done_q, done_d;

   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      ratio_d     = ratio_q;
      warm_d      = warm_q;
      rem_d       = rem_q;
      lat_d       = lat_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d     = seed;
               ratio_d = ratio;
               warm_d  = warmup;
               rem_d   = count;
               lat_d   = LAT_INIT;
               state_d = (count == '0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (abort) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else if (lat_q != '0) begin
               lat_d = lat_q - 1'b1;
            end else begin
               x_d = map_x_next_i;
               if (warm_q != '0) begin
                  warm_d = warm_q - 1'b1;
                  lat_d  = LAT_INIT;
               end else begin
                  out_data_d  = map_x_next_i;
                  out_valid_d = 1'b1;
                  state_d     = EMIT;
               end
            end
         end
         EMIT: begin
            // abort outranks a same-cycle handshake: the sample is not counted
            if (abort) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
               rem_d       = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  state_d = DONE;
               end else begin
                  lat_d   = LAT_INIT;
                  state_d = WAIT;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         x_q         <= '0;
         ratio_q     <= '0;
         warm_q      <= '0;
         rem_q       <= '0;
         lat_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         ratio_q     <= ratio_d;
         warm_q      <= warm_d;
         rem_q       <= rem_d;
         lat_q       <= lat_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign map_x_o     = x_q;
   assign map_ratio_o = ratio_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;

endmodule
